// File: rtl/e_alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : e_alu_md_unit
// Purpose  : Execute-stage arithmetic unit. A single-cycle ALU with a
//            registered result and signed-overflow flag, plus an iterative
//            multiply/divide engine that owns the HI/LO registers. ALU ops
//            stream one per cycle; MD ops run for a fixed number of cycles
//            behind busy_o.
// Ports    : clk, reset_n (async, active-low)
//            valid_i, op_i[4:0], a_i, b_i, flush_i        - request side
//            ready_o, md_stall_o                          - flow control
//            valid_o, y_o, exc_ov_o                       - ALU result
//            busy_o, hi_o, lo_o                           - MD engine state
// Revision : 1.0 - initial release
// ============================================================================
module e_alu_md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             md_stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic             exc_ov_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter only ever holds up to MAXC-1.
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_LUI   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLT   = 5'd10;
  localparam logic [4:0] OP_SLTU  = 5'd11;
  localparam logic [4:0] OP_ADDOV = 5'd12;
  localparam logic [4:0] OP_SUBOV = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MTHI  = 5'd20;
  localparam logic [4:0] OP_MTLO  = 5'd21;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  // ---------------------------------------------------------------- decode
  logic is_alu, is_md, is_mul, is_div, md_signed, accept;

  assign is_alu    = (op_i <= OP_SUBOV);
  assign is_md     = (op_i >= OP_MULT) && (op_i <= OP_MTLO);
  assign is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign md_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

  // MD ops wait for the engine; everything else (ALU, NOP) always goes.
  assign ready_o    = is_md ? !busy_o : 1'b1;
  assign md_stall_o = valid_i & is_md & busy_o;
  assign accept     = valid_i & ready_o & ~flush_i;

  // ------------------------------------------------------------------- ALU
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ov;

  assign shamt   = a_i[SHW-1:0];
  // One extra sign bit: overflow shows up as the top two bits disagreeing.
  assign add_ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
  assign sub_ext = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

  always_comb begin
    alu_y  = '0;
    alu_ov = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDOV: alu_y = add_ext[WIDTH-1:0];
      OP_SUB, OP_SUBOV: alu_y = sub_ext[WIDTH-1:0];
      OP_AND:  alu_y = a_i & b_i;
      OP_OR:   alu_y = a_i | b_i;
      OP_XOR:  alu_y = a_i ^ b_i;
      OP_NOR:  alu_y = ~(a_i | b_i);
      OP_LUI:  alu_y = b_i << (WIDTH / 2);
      OP_SLL:  alu_y = b_i << shamt;
      OP_SRL:  alu_y = b_i >> shamt;
      OP_SRA:  alu_y = WIDTH'($signed(b_i) >>> shamt);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: alu_y = '0;
    endcase
    if (op_i == OP_ADDOV) alu_ov = add_ext[WIDTH] ^ add_ext[WIDTH-1];
    if (op_i == OP_SUBOV) alu_ov = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o  <= 1'b0;
      y_o      <= '0;
      exc_ov_o <= 1'b0;
    end else begin
      valid_o <= accept & is_alu;
      if (accept & is_alu) begin
        y_o      <= alu_y;
        exc_ov_o <= alu_ov;
      end
    end
  end

  // ------------------------------------------------- MD result at issue
  // The result is computed from the operands at acceptance and held; the
  // FSM only provides the architectural latency.
  logic [2*WIDTH-1:0] a_sx, b_sx, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign a_sx = {{WIDTH{a_i[WIDTH-1] & md_signed}}, a_i};
  assign b_sx = {{WIDTH{b_i[WIDTH-1] & md_signed}}, b_i};
  assign prod = a_sx * b_sx;

  // Sign-magnitude divide. Most-negative / -1 falls out naturally:
  // |MIN| = 2^(W-1) as unsigned, and negating it gives MIN back with rem 0.
  assign a_neg = md_signed & a_i[WIDTH-1];
  assign b_neg = md_signed & b_i[WIDTH-1];
  assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;
  assign q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
  assign r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 1'b1) : r_mag;

  // ------------------------------------------------------------ MD FSM
  logic [1:0]       state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_wr;
  logic             complete;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    if (flush_i) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept & is_mul)      next_state = S_MUL;
          else if (accept & is_div) next_state = S_DIV;
        end
        S_MUL, S_DIV: if (count == '0) next_state = S_IDLE;
        default:      next_state = S_IDLE;
      endcase
    end
  end

  // Outputs of the FSM.
  always_comb begin
    busy_o   = (state != S_IDLE);
    complete = busy_o && (count == '0) && !flush_i;
  end

  // Counter and held result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      if (flush_i) begin
        count <= '0;
      end else if (accept & is_mul) begin
        count  <= MUL_LOAD;
        res_hi <= prod[2*WIDTH-1:WIDTH];
        res_lo <= prod[WIDTH-1:0];
        res_wr <= 1'b1;
      end else if (accept & is_div) begin
        count  <= DIV_LOAD;
        res_hi <= rem;
        res_lo <= quot;
        res_wr <= (b_i != '0);   // divide by zero leaves HI/LO alone
      end else if (busy_o && count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  // HI/LO. MTHI/MTLO can only be accepted while idle, so they never
  // collide with a completion write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (complete && res_wr) begin
      hi_o <= res_hi;
      lo_o <= res_lo;
    end else if (accept && op_i == OP_MTHI) begin
      hi_o <= a_i;
    end else if (accept && op_i == OP_MTLO) begin
      lo_o <= a_i;
    end
  end

endmodule
`default_nettype wire
